// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding and access latencies.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RSTROBE,
        RHOLD,
        WSTROBE,
        WHOLD,
        RESP
    } state_t;

    // Clock edges from the accept edge (counted as 1) up to the edge that raises resp_valid.
    localparam int LAT_LOAD       = 4;
    localparam int LAT_WORD_STORE = 4;
    localparam int LAT_BYTE_STORE = 6;
    localparam int LAT_ALIGN_ERR  = 1;

endpackage

// File: rtl/byte_merge.sv
// Replaces one byte lane of a 32-bit word; used to build the write word of a byte store.
module byte_merge (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    output logic [31:0] merged
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = (lane == 2'(gi)) ? byte_in : word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access sequencer with strobed memRead/memWrite and read-modify-write byte stores.
// Optional MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned word accesses with resp_err.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        memRead,
    output logic        memWrite,
    output logic        byteOperations,
    output logic [17:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    state_t      state_reg;
    logic        lat_write_reg;
    logic        lat_byte_reg;
    logic [1:0]  lat_lane_reg;
    logic [31:0] lat_wdata_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_data_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        byte_ops_reg;
    logic [17:0] address_reg;
    logic [31:0] write_data_reg;
    logic [31:0] merged_word;

    // Byte store merges straight from read_data at the end of RHOLD.
    byte_merge u_byte_merge (
        .word    (read_data),
        .lane    (lat_lane_reg),
        .byte_in (lat_wdata_reg[7:0]),
        .merged  (merged_word)
    );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic resp_err_reg;
    assign resp_err = resp_err_reg;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            lat_write_reg  <= 1'b0;
            lat_byte_reg   <= 1'b0;
            lat_lane_reg   <= 2'd0;
            lat_wdata_reg  <= 32'd0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 32'd0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            byte_ops_reg   <= 1'b0;
            address_reg    <= 18'd0;
            write_data_reg <= 32'd0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            resp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        lat_write_reg <= req_write;
                        lat_byte_reg  <= req_byte;
                        lat_lane_reg  <= req_addr[1:0];
                        lat_wdata_reg <= req_wdata;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (!req_byte && (req_addr[1:0] != 2'd0)) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_data_reg  <= 32'd0;
                            resp_err_reg   <= 1'b1;
                        end else begin
                            state_reg    <= SETUP;
                            address_reg  <= req_addr;
                            byte_ops_reg <= req_byte && !req_write;
                            resp_err_reg <= 1'b0;
                        end
`else
                        state_reg    <= SETUP;
                        address_reg  <= req_addr;
                        byte_ops_reg <= req_byte && !req_write;
`endif
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                SETUP: begin
                    if (lat_write_reg && !lat_byte_reg) begin
                        state_reg      <= WSTROBE;
                        mem_write_reg  <= 1'b1;
                        write_data_reg <= lat_wdata_reg;
                    end else begin
                        state_reg    <= RSTROBE;
                        mem_read_reg <= 1'b1;
                    end
                end
                RSTROBE: begin
                    mem_read_reg <= 1'b0;
                    state_reg    <= RHOLD;
                end
                RHOLD: begin
                    if (lat_write_reg) begin
                        state_reg      <= WSTROBE;
                        mem_write_reg  <= 1'b1;
                        write_data_reg <= merged_word;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_data_reg  <= read_data;
                        address_reg    <= 18'd0;
                        byte_ops_reg   <= 1'b0;
                    end
                end
                WSTROBE: begin
                    mem_write_reg <= 1'b0;
                    state_reg     <= WHOLD;
                end
                WHOLD: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_data_reg  <= 32'd0;
                    address_reg    <= 18'd0;
                    byte_ops_reg   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_data      = resp_data_reg;
    assign memRead        = mem_read_reg;
    assign memWrite       = mem_write_reg;
    assign byteOperations = byte_ops_reg;
    assign address        = address_reg;
    assign write_data     = write_data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a behavioural word memory and strobe monitor.
// Define MEM_ACCESS_ALIGN_CHECK_EN to expect the misaligned-access rejection path.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        memRead;
    logic        memWrite;
    logic        byteOperations;
    logic [17:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data = 32'd0;

    mem_access_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .memRead        (memRead),
        .memWrite       (memWrite),
        .byteOperations (byteOperations),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data)
    );

    always #5 clk = ~clk;

    // Behavioural memory: read data appears the cycle after memRead rises.
    bit [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (memRead) begin
            if (byteOperations)
                read_data <= {24'd0, mem[address[17:2]][address[1:0]*8 +: 8]};
            else
                read_data <= mem[address[17:2]];
        end
        if (memWrite) begin
            if (byteOperations)
                mem[address[17:2]][address[1:0]*8 +: 8] = write_data[7:0];
            else
                mem[address[17:2]] = write_data;
        end
    end

    int          rd_pulses, wr_pulses, rd_hi, wr_hi, overlap;
    logic        rd_prev = 1'b0, wr_prev = 1'b0;
    logic [31:0] cap_wdata;
    logic [17:0] cap_addr;
    logic        cap_bops;
    always @(posedge clk) begin
        if (memRead) begin
            rd_hi++;
            if (!rd_prev) rd_pulses++;
            cap_bops = byteOperations;
            cap_addr = address;
        end
        if (memWrite) begin
            wr_hi++;
            if (!wr_prev) wr_pulses++;
            cap_wdata = write_data;
            cap_addr  = address;
        end
        if (memRead && memWrite) overlap++;
        rd_prev = memRead;
        wr_prev = memWrite;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_monitor();
        rd_pulses = 0; wr_pulses = 0; rd_hi = 0; wr_hi = 0; overlap = 0;
        cap_wdata = 32'd0; cap_addr = 18'd0; cap_bops = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
    endtask

    // Drives one request, returns the accept-inclusive edge count to resp_valid.
    task automatic issue(input logic wr, input logic by, input logic [17:0] addr,
                         input logic [31:0] wdata, input string tag, output int lat);
        wait_ready(tag);
        clear_monitor();
        req_write = wr; req_byte = by; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic        by;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
        logic        exp_bops;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat;
        int n;
        logic [31:0] held;

        vecs[0] = '{1'b1, 1'b0, 18'h00010, 32'hDEADBEEF, 32'h0,        LAT_WORD_STORE, 0, 1, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 18'h00010, 32'h0,        32'hDEADBEEF, LAT_LOAD,       1, 0, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b1, 18'h00012, 32'h00000055, 32'h0,        LAT_BYTE_STORE, 1, 1, 32'hDE55BEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 18'h00013, 32'h0,        32'h000000DE, LAT_LOAD,       1, 0, 32'h0,        1'b1};
        vecs[4] = '{1'b1, 1'b0, 18'h00020, 32'h12345678, 32'h0,        LAT_WORD_STORE, 0, 1, 32'h12345678, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 18'h00020, 32'h000000AB, 32'h0,        LAT_BYTE_STORE, 1, 1, 32'h123456AB, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 18'h00023, 32'hFFFFFFCD, 32'h0,        LAT_BYTE_STORE, 1, 1, 32'hCD3456AB, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 18'h00020, 32'h0,        32'hCD3456AB, LAT_LOAD,       1, 0, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 1'b1, 18'h00021, 32'h0,        32'h00000056, LAT_LOAD,       1, 0, 32'h0,        1'b1};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 18'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        clear_monitor();

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_byte_ops", 32'(byteOperations), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            issue(vecs[i].wr, vecs[i].by, vecs[i].addr, vecs[i].wdata, tag, lat);
            check({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, "_resp_data"}, resp_data, vecs[i].exp_data);
            check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
            check({tag, "_rd_pulses"}, 32'(rd_pulses), 32'(vecs[i].exp_rd));
            check({tag, "_wr_pulses"}, 32'(wr_pulses), 32'(vecs[i].exp_wr));
            check({tag, "_rd_width"}, 32'(rd_hi), 32'(vecs[i].exp_rd));
            check({tag, "_wr_width"}, 32'(wr_hi), 32'(vecs[i].exp_wr));
            check({tag, "_overlap"}, 32'(overlap), 32'd0);
            check({tag, "_mem_addr"}, 32'(cap_addr), 32'(vecs[i].addr));
            if (vecs[i].exp_wr != 0)
                check({tag, "_write_data"}, cap_wdata, vecs[i].exp_wdata);
            if (vecs[i].exp_rd != 0)
                check({tag, "_byte_ops"}, 32'(cap_bops), 32'(vecs[i].exp_bops));
            $display("txn %s wr=%0b byte=%0b addr=0x%05h lat=%0d resp=0x%08h rd=%0d wr=%0d",
                     tag, vecs[i].wr, vecs[i].by, vecs[i].addr, lat, resp_data, rd_pulses, wr_pulses);
            release_resp(tag);
        end

        // Reset while the read phase of a byte store is in flight.
        wait_ready("midrst");
        clear_monitor();
        req_write = 1'b1; req_byte = 1'b1; req_addr = 18'h00022; req_wdata = 32'h00000077;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!memRead && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("midrst_in_rstrobe", 32'(memRead), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_address", 32'(address), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(wr_pulses), 32'd0);
        check("midrst_mem_word", mem[8], 32'hCD3456AB);
        check("midrst_ready_after", 32'(req_ready), 32'd1);
        $display("txn midrst byte store 0x00022 aborted wr_pulses=%0d mem=0x%08h", wr_pulses, mem[8]);

        issue(1'b0, 1'b0, 18'h00020, 32'h0, "postrst", lat);
        check("postrst_resp_data", resp_data, 32'hCD3456AB);
        $display("txn postrst load 0x00020 resp=0x%08h", resp_data);
        release_resp("postrst");

        // Misaligned word load, response held with resp_ready low.
        issue(1'b0, 1'b0, 18'h00011, 32'h0, "misal", lat);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        check("misal_latency", 32'(lat), 32'(LAT_ALIGN_ERR));
        check("misal_resp_err", 32'(resp_err), 32'd1);
        check("misal_resp_data", resp_data, 32'd0);
        check("misal_rd_pulses", 32'(rd_pulses), 32'd0);
        held = 32'd0;
`else
        check("misal_latency", 32'(lat), 32'(LAT_LOAD));
        check("misal_resp_err", 32'(resp_err), 32'd0);
        check("misal_resp_data", resp_data, 32'hDE55BEEF);
        check("misal_rd_pulses", 32'(rd_pulses), 32'd1);
        held = 32'hDE55BEEF;
`endif
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("misal_hold%0d_valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("misal_hold%0d_data", c), resp_data, held);
        end
        check("misal_wr_pulses", 32'(wr_pulses), 32'd0);
        $display("txn misal load 0x00011 lat=%0d resp=0x%08h err=%0b", lat, resp_data, resp_err);
        release_resp("misal");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 1, CPU access request present.
REQ-004 SHALL have port req_ready, output, 1, controller idle and accepting a request.
REQ-005 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port req_byte, input, 1, 1 = byte access (lb/sb), 0 = word access.
REQ-007 SHALL have port req_addr, input, 18, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data; a byte store uses [7:0].
REQ-009 SHALL have port resp_valid, output, 1, access complete.
REQ-010 SHALL have port resp_ready, input, 1, CPU consumes the response.
REQ-011 SHALL have port resp_data, output, 32, load result; 0 for stores.
REQ-012 SHALL have port resp_err, output, 1, access rejected (see Configuration).
REQ-013 SHALL have ports memRead and memWrite, output, 1 each; the memory acts on their rising edge.
REQ-014 SHALL have port byteOperations, output, 1, memory byte mode.
REQ-015 SHALL have ports address (output, 18) and write_data (output, 32) toward memory.
REQ-016 SHALL have port read_data, input, 32, memory read result; valid from the cycle after memRead rises.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, RSTROBE, RHOLD, WSTROBE, WHOLD, RESP.
REQ-018 SHALL assert req_ready only in IDLE; req_valid&&req_ready latches all req_* fields, IDLE->SETUP.
REQ-019 SHALL drive address and byteOperations from the latched request from SETUP until leaving WHOLD/RHOLD, with both strobes low in SETUP.
REQ-020 SHALL route loads SETUP->RSTROBE->RHOLD->RESP; memRead=1 only in RSTROBE; resp_data captured from read_data at the end of RHOLD.
REQ-021 SHALL drive byteOperations=1 for byte loads, so resp_data = zero-extended byte from memory.
REQ-022 SHALL route word stores SETUP->WSTROBE->WHOLD->RESP; memWrite=1 only in WSTROBE; write_data=req_wdata.
REQ-023 SHALL perform byte stores as read-modify-write with byteOperations=0: SETUP->RSTROBE->RHOLD->WSTROBE->WHOLD->RESP, with write_data = captured word with lane addr[1:0] (bits addr[1:0]*8+:8) replaced by req_wdata[7:0] and other bytes preserved.
REQ-024 SHALL never assert memRead and memWrite together; each strobe SHALL be high exactly one cycle per phase, low before and after.
REQ-025 SHALL hold resp_valid=1 in RESP until resp_ready=1, then return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-026 SHALL give fixed latency from accept edge to resp_valid: load 4 cycles, word store 4, byte store 6.
REQ-027 SHALL hold resp_data and resp_err stable while resp_valid=1.

Reset
REQ-028 SHALL, when reset=1 at a clock edge in any state (mid-access included), enter IDLE and set memRead=0, memWrite=0, byteOperations=0, address=0, write_data=0, resp_valid=0, resp_data=0, resp_err=0, req_ready=0 during reset, 1 the cycle after release.

Configuration
REQ-029 SHALL, with MEM_ACCESS_ALIGN_CHECK_EN defined, route a word request with req_addr[1:0]!=0 IDLE->RESP directly, with resp_err=1, resp_data=0 and no strobe asserted.
REQ-030 SHALL, without MEM_ACCESS_ALIGN_CHECK_EN, ignore req_addr[1:0] for word accesses (memory uses [17:2]) and tie resp_err to 0.

Structure
REQ-031 SHALL place the state enumeration and the latency constants in shared package mem_pkg.
REQ-032 SHALL place byte-lane merge logic in sub-module byte_merge (word, lane, byte -> merged word); all else is flat.

Verification
REQ-033 SHALL check word store addr=0x00010, wdata=0xDEADBEEF: one memWrite pulse, address=0x00010, resp_valid 4 cycles after accept.
REQ-034 SHALL check word load from 0x00010 after REQ-033: exactly one memRead pulse, resp_data=0xDEADBEEF.
REQ-035 SHALL check byte store 0x55 to 0x00012 over 0xDEADBEEF: memRead then memWrite pulse, write_data=0xDE55BEEF, resp at 6 cycles.
REQ-036 SHALL check byte load from 0x00013 after REQ-035: byteOperations=1, resp_data=0x000000DE.
REQ-037 SHALL check reset asserted during RSTROBE of a byte store: next cycle both strobes 0, no memWrite ever issued, memory word unchanged.
REQ-038 SHALL check that, with MEM_ACCESS_ALIGN_CHECK_EN, a word load at 0x00011 gives resp_err=1, resp_data=0, no strobes; and that resp_valid holds for 3 cycles with resp_ready=0.
